// File: rtl/axi_read_arbiter_pkg.sv
// axi_arb_pkg: shared types and constants for the AXI read arbiter
package axi_arb_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b11
  } state_t;
  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;
  localparam logic [2:0] ARSIZE_WORD  = 3'b010;
  localparam logic [1:0] ARBURST_INCR = 2'b01;
endpackage

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt: saturating counter of arbitration rounds the I requester has lost
module arb_starve_cnt #(
  parameter int LIMIT = 8,
  localparam int W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    sat   = cnt_q == W'(LIMIT);
    cnt_d = clr ? '0 : (inc && !sat) ? cnt_q + W'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: whole-transaction AR+R arbiter between i_cache and d_cache, D priority with I starvation override
module axi_read_arbiter
  import axi_arb_pkg::*;
#(
  parameter int         STARVE_LIMIT = 8,
  parameter logic [3:0] INST_ID      = 4'd0,
  parameter logic [3:0] DATA_ID      = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_araddr,
  input  logic [3:0]  inst_arlen,
  input  logic        inst_arvalid,
  output logic        inst_arready,
  output logic [31:0] inst_rdata,
  output logic        inst_rlast,
  output logic        inst_rvalid,
  input  logic        inst_rready,
  input  logic [31:0] data_araddr,
  input  logic [3:0]  data_arlen,
  input  logic        data_arvalid,
  output logic        data_arready,
  output logic [31:0] data_rdata,
  output logic        data_rlast,
  output logic        data_rvalid,
  input  logic        data_rready,
  output logic [31:0] m_araddr,
  output logic [3:0]  m_arlen,
  output logic [3:0]  m_arid,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [3:0]  m_rid,
  input  logic        m_rlast,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic        rid_err
);
  state_t state_q, state_d;
  grant_t grant_q, grant_d;
  logic rid_err_q, rid_err_d;
  logic cnt_inc, cnt_clr, cnt_sat;
  logic sel_d, sel_i, is_d, in_addr, in_data, g_arvalid, g_rready;
  logic [3:0] g_id;
  arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (cnt_inc),
    .clr (cnt_clr),
    .sat (cnt_sat)
  );
  always_comb begin
    is_d      = grant_q == GRANT_D;
    in_addr   = state_q == ADDR;
    in_data   = state_q == DATA;
    g_arvalid = is_d ? data_arvalid : inst_arvalid;
    g_rready  = is_d ? data_rready : inst_rready;
    g_id      = is_d ? DATA_ID : INST_ID;
    sel_d     = data_arvalid && !(inst_arvalid && cnt_sat);
    sel_i     = !sel_d && inst_arvalid;
    cnt_inc   = state_q == IDLE && inst_arvalid && sel_d;
    cnt_clr   = state_q == IDLE && (sel_i || !inst_arvalid);
    state_d   = state_q;
    grant_d   = grant_q;
    case (state_q)
      IDLE: if (sel_d || sel_i) begin
        state_d = ADDR;
        grant_d = sel_d ? GRANT_D : GRANT_I;
      end
      ADDR:    state_d = (g_arvalid && m_arready) ? DATA : g_arvalid ? ADDR : IDLE;
      DATA:    state_d = (m_rvalid && g_rready && m_rlast) ? IDLE : DATA;
      default: state_d = IDLE;
    endcase
    rid_err_d = rid_err_q || (in_data && m_rvalid && m_rid != g_id);
  end
  always_comb begin
    m_arvalid    = in_addr && g_arvalid;
    m_araddr     = in_addr ? (is_d ? data_araddr : inst_araddr) : '0;
    m_arlen      = in_addr ? (is_d ? data_arlen : inst_arlen) : '0;
    m_arid       = in_addr ? g_id : '0;
    m_arsize     = ARSIZE_WORD;
    m_arburst    = ARBURST_INCR;
    inst_arready = in_addr && !is_d && m_arready;
    data_arready = in_addr && is_d && m_arready;
    m_rready     = in_data && g_rready;
    inst_rvalid  = in_data && !is_d && m_rvalid;
    inst_rlast   = in_data && !is_d && m_rlast;
    data_rvalid  = in_data && is_d && m_rvalid;
    data_rlast   = in_data && is_d && m_rlast;
    inst_rdata   = m_rdata;
    data_rdata   = m_rdata;
    rid_err      = rid_err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= GRANT_I;
      rid_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rid_err_q <= rid_err_d;
    end
  end
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: directed scenarios plus randomized traffic checked against a transaction-level model
module tb_axi_read_arbiter;
  localparam int LIM = 8;
  logic clk = 0, rst;
  logic [31:0] inst_araddr, data_araddr, inst_rdata, data_rdata, m_araddr, m_rdata;
  logic [3:0] inst_arlen, data_arlen, m_arlen, m_arid, m_rid;
  logic inst_arvalid, inst_arready, inst_rlast, inst_rvalid, inst_rready;
  logic data_arvalid, data_arready, data_rlast, data_rvalid, data_rready;
  logic [2:0] m_arsize;
  logic [1:0] m_arburst;
  logic m_arvalid, m_arready, m_rlast, m_rvalid, m_rready, rid_err;
  axi_read_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_araddr(inst_araddr), .inst_arlen(inst_arlen), .inst_arvalid(inst_arvalid), .inst_arready(inst_arready),
    .inst_rdata(inst_rdata), .inst_rlast(inst_rlast), .inst_rvalid(inst_rvalid), .inst_rready(inst_rready),
    .data_araddr(data_araddr), .data_arlen(data_arlen), .data_arvalid(data_arvalid), .data_arready(data_arready),
    .data_rdata(data_rdata), .data_rlast(data_rlast), .data_rvalid(data_rvalid), .data_rready(data_rready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arid(m_arid), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rdata(m_rdata), .m_rid(m_rid), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .rid_err(rid_err)
  );
  always #5 clk = ~clk;
  int checks = 0, fails = 0;
  // reference model: who owns the bus, which phase, lost-round count, sticky id error
  int ms = 0, mg = 0, mcnt = 0;
  bit merr = 0;
  // stimulus shadows, applied at each falling edge
  bit s_rst = 1, s_iv = 0, s_dv = 0, s_irr = 1, s_drr = 1, rnd = 0, bad_rid = 0;
  logic [31:0] s_ia = 0, s_da = 0;
  logic [3:0] s_il = 0, s_dl = 0, bus_id = 0;
  int bus_left = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic rand_drive();
    s_rst = $urandom % 200 == 0;
    if (!s_iv && $urandom % 100 < 30) begin
      s_iv = 1; s_ia = $urandom; s_il = 4'($urandom % 8);
    end else if (s_iv && $urandom % 80 == 0) s_iv = 0;
    if (!s_dv && $urandom % 100 < 50) begin
      s_dv = 1; s_da = $urandom; s_dl = 4'($urandom % 8);
    end else if (s_dv && $urandom % 80 == 0) s_dv = 0;
    s_irr = $urandom % 4 != 0;
    s_drr = $urandom % 4 != 0;
  endtask
  task automatic compare();
    bit ad, dt, gd, gv;
    ad = ms == 1; dt = ms == 2; gd = mg == 1;
    gv = gd ? data_arvalid : inst_arvalid;
    chk("m_arvalid", m_arvalid, ad && gv);
    chk("m_araddr", m_araddr, ad ? (gd ? data_araddr : inst_araddr) : 0);
    chk("m_arlen", m_arlen, ad ? (gd ? data_arlen : inst_arlen) : 0);
    chk("m_arid", m_arid, ad ? mg : 0);
    chk("m_arsize", m_arsize, 2);
    chk("m_arburst", m_arburst, 1);
    chk("inst_arready", inst_arready, ad && !gd && m_arready);
    chk("data_arready", data_arready, ad && gd && m_arready);
    chk("m_rready", m_rready, dt && (gd ? data_rready : inst_rready));
    chk("inst_rvalid", inst_rvalid, dt && !gd && m_rvalid);
    chk("inst_rlast", inst_rlast, dt && !gd && m_rlast);
    chk("data_rvalid", data_rvalid, dt && gd && m_rvalid);
    chk("data_rlast", data_rlast, dt && gd && m_rlast);
    chk("inst_rdata", inst_rdata, m_rdata);
    chk("data_rdata", data_rdata, m_rdata);
    chk("rid_err", rid_err, merr);
    if (rst) begin
      ms = 0; mg = 0; mcnt = 0; merr = 0;
    end else if (ms == 0) begin
      if (data_arvalid && !(inst_arvalid && mcnt == LIM)) begin
        ms = 1; mg = 1;
        if (inst_arvalid) mcnt = mcnt < LIM ? mcnt + 1 : LIM;
      end else if (inst_arvalid) begin
        ms = 1; mg = 0; mcnt = 0;
      end
      if (!inst_arvalid) mcnt = 0;
    end else if (ms == 1) begin
      if (gv && m_arready) ms = 2;
      else if (!gv) ms = 0;
    end else begin
      if (m_rvalid && m_rid != 4'(mg)) merr = 1;
      if (m_rvalid && m_rlast && (gd ? data_rready : inst_rready)) ms = 0;
    end
  endtask
  task automatic step();
    @(negedge clk);
    if (rnd) rand_drive();
    rst = s_rst;
    inst_arvalid = s_iv; inst_araddr = s_ia; inst_arlen = s_il; inst_rready = s_irr;
    data_arvalid = s_dv; data_araddr = s_da; data_arlen = s_dl; data_rready = s_drr;
    m_arready = rnd ? $urandom % 10 < 7 : 1'b1;
    if (bus_left > 0 && (!rnd || $urandom % 10 < 7)) begin
      m_rvalid = 1; m_rlast = bus_left == 1;
      m_rid = (bad_rid || (rnd && $urandom % 50 == 0)) ? bus_id ^ 4'h1 : bus_id;
    end else begin
      m_rvalid = 0; m_rlast = 1'($urandom); m_rid = 4'($urandom);
    end
    m_rdata = $urandom;
    #1;
    compare();
    if (rst) bus_left = 0;
    else begin
      if (m_rvalid && m_rready && bus_left > 0) bus_left--;
      if (m_arvalid && m_arready) begin bus_left = int'(m_arlen) + 1; bus_id = m_arid; end
    end
    if (inst_arvalid && inst_arready) s_iv = 0;
    if (data_arvalid && data_arready) s_dv = 0;
  endtask
  task automatic wait_last(input bit d, output int nb, output bit oth, output bit iar);
    nb = 0; oth = 0; iar = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (d ? data_rvalid && data_rready : inst_rvalid && inst_rready) nb++;
      if (d ? inst_rvalid : data_rvalid) oth = 1;
      if (inst_arready) iar = 1;
      if (d ? data_rvalid && data_rlast && data_rready : inst_rvalid && inst_rlast && inst_rready) return;
    end
    checks++; fails++;
    $display("FAIL wait_last: no rlast within 60 cycles");
  endtask
  initial begin
    int nb, gap, dw;
    bit oth, iar;
    rst = 1; inst_arvalid = 0; data_arvalid = 0; m_arvalid = 0; m_rvalid = 0;
    step(); step(); s_rst = 0; step();
    chk("rst_arvalid", m_arvalid, 0); chk("rst_arsize", m_arsize, 3'b010);
    chk("rst_arburst", m_arburst, 2'b01); chk("rst_rid_err", rid_err, 0); chk("rst_m_rready", m_rready, 0);
    // I alone, 8-beat burst
    s_iv = 1; s_ia = 32'h1FC0_0000; s_il = 7; step();
    chk("t1_arb_cycle", m_arvalid, 0);
    step();
    chk("t1_arvalid", m_arvalid, 1); chk("t1_arid", m_arid, 0); chk("t1_arlen", m_arlen, 7);
    chk("t1_araddr", m_araddr, 32'h1FC0_0000);
    wait_last(0, nb, oth, iar);
    chk("t1_beats", nb, 8); chk("t1_no_data_rvalid", oth, 0);
    // simultaneous I and D
    s_iv = 1; s_ia = 32'h0000_1000; s_il = 1; s_dv = 1; s_da = 32'h8000_0040; s_dl = 3;
    step(); step();
    chk("t2_d_first", m_arid, 1); chk("t2_i_arready", inst_arready, 0);
    wait_last(1, nb, oth, iar);
    chk("t2_d_beats", nb, 4); chk("t2_i_held", iar, 0);
    gap = 0;
    for (int k = 0; k < 10; k++) begin step(); gap++; if (m_arvalid) break; end
    chk("t2_gap", gap, 2); chk("t2_i_id", m_arid, 0);
    wait_last(0, nb, oth, iar);
    // uncached single beat
    s_iv = 1; s_ia = 32'hBFC0_0004; s_il = 0; step(); step();
    chk("t4_arvalid", m_arvalid, 1); chk("t4_arlen", m_arlen, 0);
    step();
    chk("t4_rvalid", inst_rvalid, 1); chk("t4_rlast", inst_rlast, 1);
    step();
    chk("t4_idle", m_rready, 0);
    // starvation override
    s_iv = 1; s_ia = 32'h0000_2000; s_il = 0; s_dv = 1; s_da = 32'h8000_0100; s_dl = 0; dw = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (data_arvalid && data_arready) begin dw++; s_dv = 1; end
      if (inst_arvalid && inst_arready) break;
    end
    chk("t3_d_wins", dw, LIM);
    s_iv = 1;
    wait_last(0, nb, oth, iar);
    for (int k = 0; k < 5; k++) begin step(); if (m_arvalid) break; end
    chk("t3_cnt_cleared", m_arid, 1);
    s_iv = 0;
    wait_last(1, nb, oth, iar);
    // reset mid-burst
    s_iv = 1; s_ia = 32'h0000_3000; s_il = 7; nb = 0;
    for (int k = 0; k < 40 && nb < 2; k++) begin step(); if (inst_rvalid && inst_rready) nb++; end
    s_rst = 1; step(); s_rst = 0; step();
    chk("t5_rvalid", inst_rvalid, 0); chk("t5_m_rready", m_rready, 0);
    chk("t5_arvalid", m_arvalid, 0); chk("t5_arready", inst_arready, 0);
    s_iv = 1; s_il = 1; step(); step();
    chk("t5_reissue", m_arvalid, 1);
    wait_last(0, nb, oth, iar);
    chk("t5_beats", nb, 2);
    // wrong read id
    bad_rid = 1; s_iv = 1; s_il = 1; step(); step();
    wait_last(0, nb, oth, iar);
    bad_rid = 0;
    chk("t6_rid_err", rid_err, 1);
    step(); step();
    chk("t6_sticky", rid_err, 1);
    s_rst = 1; step(); s_rst = 0; step();
    chk("t6_cleared", rid_err, 0);
    rnd = 1;
    for (int k = 0; k < 4000; k++) step();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
